telemetry_framer: RTL

- Sits between the robot status logic (motor state, proximity reading) and the uart_tx instance.
- Replaces the single status byte sent on every received UART byte with a framed, checksummed 5-byte telemetry packet.
- Sends a packet periodically, and also immediately when the motor state changes.
- Drives uart_tx through its valid/ready handshake.

---
 rtl/telemetry_framer.sv | 106 ++++++++++
 1 files changed

// File: rtl/telemetry_framer.sv
// Frames robot status into 5-byte checksummed telemetry packets for uart_tx.
// Packets go out periodically and on every motor-state change; one extra request is queued while busy.
module telemetry_framer #(
  parameter int unsigned PERIOD_CYCLES = 5_000_000,
  parameter logic [7:0]  HEADER        = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] motor_stat,
  input  logic [7:0] prox_raw,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] seq
);

  localparam int unsigned TW = $clog2(PERIOD_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    last_motor;
  logic          pending;
  logic [7:0]    frame [1:4];
  logic [2:0]    idx;

  logic       tick;
  logic       chg;
  logic       trigger;
  logic       accept;
  logic [3:0] prox_sat;
  logic [7:0] status_byte;

  assign tick        = (timer == TW'(PERIOD_CYCLES - 1));
  assign chg         = (motor_stat != last_motor);
  assign trigger     = tick | chg;
  assign accept      = tx_valid & tx_ready;
  assign prox_sat    = (prox_raw > 8'd63) ? 4'hF : prox_raw[5:2];
  assign status_byte = {prox_sat, motor_stat, 1'b1};

  // Free-running period timer; change-triggered frames never restart it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      seq        <= '0;
      busy       <= 1'b0;
      pending    <= 1'b0;
      last_motor <= '0;
      idx        <= '0;
    end else begin
      last_motor <= motor_stat;
      if (trigger && (state != IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (trigger || pending) begin
            state   <= LOAD;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        LOAD: begin
          // Header goes straight to tx_data; only bytes 1..4 need buffering.
          frame[1] <= seq;
          frame[2] <= status_byte;
          frame[3] <= prox_raw;
          frame[4] <= HEADER ^ seq ^ status_byte ^ prox_raw;
          idx      <= '0;
          tx_data  <= HEADER;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (accept) begin
            if (idx == 3'd4) begin
              tx_valid <= 1'b0;
              seq      <= seq + 8'd1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= frame[idx + 3'd1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
